// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared types and constants for the stopwatch time base: FSM state
//   encoding, button event encoding, counter widths and wrap limits, and the
//   packed H:MM:SS.mmm time record used for the live count and lap snapshot.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  // One event per cycle after priority resolution.
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_SS   = 2'd1,
    EV_LAP  = 2'd2,
    EV_CLR  = 2'd3
  } sw_event_e;

  localparam int HR_W  = 4;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int MS_W  = 10;

  localparam logic [MS_W-1:0]  MS_MAX   = 10'd999;
  localparam logic [SEC_W-1:0] SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX  = 6'd59;
  localparam logic [HR_W-1:0]  HOUR_MAX = 4'd9;

  // Field order matches the display order so a packed compare reads naturally.
  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
    logic [MS_W-1:0]  ms;
  } sw_time_t;

  // start_stop beats lap beats clear; losers in the same cycle are dropped.
  function automatic sw_event_e sel_event(input logic ss, input logic lap,
                                          input logic clr);
    sw_event_e ev;
    ev = EV_NONE;
    if (ss)       ev = EV_SS;
    else if (lap) ev = EV_LAP;
    else if (clr) ev = EV_CLR;
    return ev;
  endfunction

endpackage

// File: rtl/button_edge_sync.sv
// button_edge_sync
//   Two-flop synchronizer for an asynchronous, externally debounced button,
//   followed by a rising-edge detector producing a single-cycle pulse.
//   Ports:
//     clk      - system clock
//     rst_n    - asynchronous active-low reset (all flops to 0)
//     i_btn    - raw button level, asynchronous to clk
//     o_pulse  - one-cycle pulse on each synchronized rising edge
module button_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  // Button sampled at edge N -> r_sync high after N+1 -> pulse acted on at N+2.
  assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   1 ms time base plus H:MM:SS.mmm stopwatch with start/stop, lap and clear
//   buttons. Feeds the frame drawer with binary hours/minutes/seconds/ms.
//   Ports:
//     clk, rst_n                         - clock, async active-low reset
//     start_stop_btn, lap_btn, clear_btn - async, debounced, active-high
//     hours[3:0], minutes[5:0], seconds[5:0], milliseconds[9:0]
//                                        - live count, or lap snapshot in LAP
//     running     - state is RUN or LAP
//     lap_active  - state is LAP
//     overflow    - sticky, set when 9:59:59.999 wraps to zero
//   CLK_FREQ_HZ must be a multiple of 1000 and at least 1000.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_stop_btn,
  input  logic             lap_btn,
  input  logic             clear_btn,
  output logic [HR_W-1:0]  hours,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic [MS_W-1:0]  milliseconds,
  output logic             running,
  output logic             lap_active,
  output logic             overflow
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam int NUM_BTN  = 3;

  // ---------------------------------------------------------------- buttons
  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_btn_pulse;

  assign w_btn_raw = {clear_btn, lap_btn, start_stop_btn};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_edge_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (w_btn_raw[g]),
      .o_pulse (w_btn_pulse[g])
    );
  end

  sw_event_e w_event;
  assign w_event = sel_event(w_btn_pulse[0], w_btn_pulse[1], w_btn_pulse[2]);

  // -------------------------------------------------------------------- FSM
  sw_state_e r_state;
  sw_state_e w_state_nxt;
  logic      w_clr;       // PAUSE -> IDLE: wipe everything
  logic      w_lap_load;  // RUN -> LAP: capture snapshot

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_lap_load  = 1'b0;
    case (r_state)
      IDLE:  if (w_event == EV_SS) w_state_nxt = RUN;
      RUN: begin
        if (w_event == EV_SS) begin
          w_state_nxt = PAUSE;
        end else if (w_event == EV_LAP) begin
          w_state_nxt = LAP;
          w_lap_load  = 1'b1;
        end
      end
      LAP: begin
        if (w_event == EV_SS)       w_state_nxt = PAUSE;
        else if (w_event == EV_LAP) w_state_nxt = RUN;
      end
      PAUSE: begin
        if (w_event == EV_SS) begin
          w_state_nxt = RUN;
        end else if (w_event == EV_CLR) begin
          w_state_nxt = IDLE;
          w_clr       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------- prescaler
  logic             w_counting;
  logic             w_tick;
  logic [PRE_W-1:0] r_presc;

  assign w_counting = (r_state == RUN) || (r_state == LAP);
  assign w_tick     = w_counting && (r_presc == PRE_LAST);

  // Held (not cleared) in PAUSE so a partial millisecond survives a pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_presc <= '0;
    else if (w_clr || r_state == IDLE)   r_presc <= '0;
    else if (w_tick)                     r_presc <= '0;
    else if (w_counting)                 r_presc <= r_presc + PRE_W'(1);
  end

  // ---------------------------------------------------------------- cascade
  sw_time_t r_live;
  sw_time_t w_live_nxt;
  logic     w_wrap;

  always_comb begin
    w_live_nxt = r_live;
    w_wrap     = 1'b0;
    if (r_live.ms != MS_MAX) begin
      w_live_nxt.ms = r_live.ms + 1'b1;
    end else begin
      w_live_nxt.ms = '0;
      if (r_live.sec != SEC_MAX) begin
        w_live_nxt.sec = r_live.sec + 1'b1;
      end else begin
        w_live_nxt.sec = '0;
        if (r_live.min != MIN_MAX) begin
          w_live_nxt.min = r_live.min + 1'b1;
        end else begin
          w_live_nxt.min = '0;
          if (r_live.hr != HOUR_MAX) begin
            w_live_nxt.hr = r_live.hr + 1'b1;
          end else begin
            w_live_nxt.hr = '0;
            w_wrap        = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_live <= '0;
    else if (w_clr)  r_live <= '0;
    else if (w_tick) r_live <= w_live_nxt;
  end

  logic r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_overflow <= 1'b0;
    else if (w_clr)            r_overflow <= 1'b0;
    else if (w_tick && w_wrap) r_overflow <= 1'b1;
  end

  // --------------------------------------------------------------- snapshot
  // Takes r_live as registered before the LAP-entry edge, so a coincident
  // tick is not included in the snapshot.
  sw_time_t r_snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_snap <= '0;
    else if (w_clr)      r_snap <= '0;
    else if (w_lap_load) r_snap <= r_live;
  end

  // ----------------------------------------------------------------- output
  sw_time_t w_disp;

  assign w_disp       = (r_state == LAP) ? r_snap : r_live;
  assign hours        = w_disp.hr;
  assign minutes      = w_disp.min;
  assign seconds      = w_disp.sec;
  assign milliseconds = w_disp.ms;
  assign running      = w_counting;
  assign lap_active   = (r_state == LAP);
  assign overflow     = r_overflow;

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-base and stopwatch control block that feeds the frame-drawing stage. It converts the system clock into a 1 ms tick and runs a cascaded H:MM:SS.mmm counter under start/stop, lap and clear buttons. Its binary `hours`, `minutes`, `seconds` and `milliseconds` outputs connect directly to the image drawer's inputs of the same names and widths.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency.
  - Must be an integer multiple of 1000 and at least 1000.
  - Derived constant `TICK_DIV = CLK_FREQ_HZ/1000`, the number of clock cycles per millisecond.
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst_n`, in, 1: one clock; reset is asynchronous and active-low.
- `start_stop_btn`, in, 1: start/stop button. Asynchronous to `clk`, debounced externally, active-high.
- `lap_btn`, in, 1: lap button. Same electrical properties as `start_stop_btn`.
- `clear_btn`, in, 1: clear button. Same electrical properties as `start_stop_btn`.
- `hours`, out, 4: displayed hours, range 0–9.
- `minutes`, out, 6: displayed minutes, range 0–59.
- `seconds`, out, 6: displayed seconds, range 0–59.
- `milliseconds`, out, 10: displayed milliseconds, range 0–999.
- `running`, out, 1: high in states RUN and LAP.
- `lap_active`, out, 1: high in state LAP.
- `overflow`, out, 1: sticky; set when the count wraps from 9:59:59.999 to zero.

## Operation
- Button inputs:
  - Each button passes through a 2-flop synchronizer followed by a rising-edge detector.
  - Each detected edge produces a 1-cycle event. Holding a button high produces no further events.
- Simultaneous events in the same cycle, priority order:
  - start_stop > lap > clear.
  - Lower-priority events in that cycle are discarded.
- FSM states: IDLE, RUN, PAUSE, LAP. Reset state is IDLE.
  - IDLE: start_stop → RUN. lap and clear are ignored.
  - RUN: start_stop → PAUSE. lap → LAP and loads the snapshot. clear is ignored.
  - LAP: lap → RUN, and the outputs return to the live count. start_stop → PAUSE, and the outputs show the live (stopped) count. clear is ignored.
  - PAUSE: start_stop → RUN. clear → IDLE. lap is ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN and LAP.
  - The tick fires in the cycle where the count equals TICK_DIV-1; the prescaler returns to 0 on that edge.
  - Holds its value in PAUSE, so a partial millisecond is kept.
  - Forced to 0 in IDLE.
- Counter cascade, advanced once per tick:
  - ms 999 → 0 carries into seconds.
  - sec 59 → 0 carries into minutes.
  - min 59 → 0 carries into hours.
  - hr 9 → 0 sets `overflow`; counting continues.
  - All counters are plain binary, sized exactly to the output widths.
- Clear (PAUSE → IDLE) zeroes all counters, the prescaler, the snapshot and `overflow`.
- Lap snapshot:
  - On the edge that enters LAP, the snapshot loads the live counter values registered before that edge.
  - If a tick coincides with that edge, the live count increments but the snapshot takes the pre-increment value.
- Output mux: outputs show the snapshot in LAP and the live counters in every other state.

## Timing
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - Prescaler, counters, snapshot and synchronizer flops are all 0.
- Button-to-state latency:
  - The button is sampled high at edge N; the state changes at edge N+2.
  - `running` and `lap_active` are decoded from the registered state and change with it.
- First tick occurs TICK_DIV cycles after the edge that enters RUN from IDLE.
- After resuming from PAUSE, the first tick occurs after the remaining prescaler count.
- Counter outputs update on the tick edge, with no added latency.
- Reset asserted mid-operation:
  - All state clears immediately and asynchronously.
  - Counting restarts only after a fresh start_stop edge following reset release.
- The synchronizer flops are also reset to 0, so a button already held high when reset releases produces a start_stop event 2 cycles later.

## Structure
- Package `stopwatch_pkg` holds:
  - the state enum `{IDLE, RUN, PAUSE, LAP}`;
  - the limit constants `MS_MAX=999`, `SEC_MAX=59`, `MIN_MAX=59`, `HOUR_MAX=9`;
  - the output width constants 4, 6, 6, 10.
- Sub-module `button_edge_sync`: 2-flop synchronizer plus rising-edge pulse, same `clk`/`rst_n`. It is instantiated three times.
- The top level contains the FSM, prescaler, counter cascade, snapshot registers and output mux.

## Test plan
- **Reset:** assert `rst_n`=0 mid-count with `TICK_DIV`=10 → all outputs 0, state IDLE, `running`=0 immediately, with no clock edge needed.
- **Basic count:** `CLK_FREQ_HZ`=10_000, press start_stop → `running`=1 two edges later. 10_000 cycles after entering RUN, `seconds`=1 and `milliseconds`=0.
- **Lap:** at 0:00:01.234, press lap → outputs hold 1.234 and `lap_active`=1. Press lap again 5000 cycles later → outputs show 0:00:01.734 live and `lap_active`=0.
- **Pause and clear:**
  - Pause at prescaler=7, resume → next ms tick comes 2 cycles after re-entering RUN.
  - clear while RUN has no effect.
  - clear while PAUSE → all zero, IDLE, `overflow`=0.
- **Wrap:** `CLK_FREQ_HZ`=1000, run 35_999_999 ticks → outputs read 9:59:59.999. The next tick gives 0:00:00.000 with `overflow`=1, and `running` stays 1.
- **Simultaneous edges:**
  - start_stop and lap rising together in RUN → PAUSE, no snapshot, `lap_active`=0.
  - start_stop and clear together in PAUSE → RUN, counters retained.
